// File: rtl/dcache.sv
// 2-way set-associative, write-back, write-allocate data cache with 2-word blocks and per-set LRU.
// Misses and the halt-time flush use a single word-at-a-time memory port.
module dcache #(
  parameter int SETS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        halt,
  input  logic        dmemren,
  input  logic        dmemwen,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemstore,
  output logic        dhit,
  output logic [31:0] dmemload,
  output logic        flushed,
  output logic        dren,
  output logic        dwen,
  output logic [31:0] daddr,
  output logic [31:0] dstore,
  input  logic        dwait,
  input  logic [31:0] dload,
  output logic [3:0]  dbg_state
);
  localparam int IDXW = $clog2(SETS);
  localparam int TAGW = 32 - IDXW - 3;

  // Memory handshake: a dren/dwen request holds address, data and direction
  // stable while dwait=1; the word moves on the first cycle sampled with dwait=0.
  typedef enum logic [3:0] {
    IDLE, WB0, WB1, FETCH0, FETCH1, FLUSH0, FLUSH1, NEXT, HALTED
  } state_t;

  state_t state, state_d;

  logic            valid_q [SETS][2];
  logic            dirty_q [SETS][2];
  logic            lru_q   [SETS];
  logic [TAGW-1:0] tag_q   [SETS][2];
  logic [31:0]     data_q  [SETS][2][2];

  logic            vway_q;
  logic [IDXW-1:0] midx_q;
  logic [TAGW-1:0] mtag_q;
  logic [IDXW:0]   fc_q;

  logic [IDXW-1:0] ridx;
  logic [TAGW-1:0] rtag;
  logic            rword;
  logic            req, hit0, hit1, hit, hway;
  logic            idle_go, do_hit, do_write, do_miss;
  logic            fill0, fill1, flush_done, flush_skip;
  logic [IDXW-1:0] fset;
  logic            fway, flast, fdirty;
  logic            second;
  logic            unused_addr;

  assign ridx  = dmemaddr[IDXW+2:3];
  assign rtag  = dmemaddr[31:IDXW+3];
  assign rword = dmemaddr[2];
  assign unused_addr = ^dmemaddr[1:0];

  assign req  = dmemren | dmemwen;
  assign hit0 = valid_q[ridx][0] && (tag_q[ridx][0] == rtag);
  assign hit1 = valid_q[ridx][1] && (tag_q[ridx][1] == rtag);
  assign hit  = hit0 | hit1;
  assign hway = hit1 & ~hit0;

  // halt outranks any pending request, so nothing hits once a flush is due
  assign idle_go  = (state == IDLE) && !halt;
  assign do_hit   = idle_go && req && hit;
  assign do_write = do_hit && dmemwen;
  assign do_miss  = idle_go && req && !hit;

  assign fill0      = (state == FETCH0) && !dwait;
  assign fill1      = (state == FETCH1) && !dwait;
  assign fset       = fc_q[IDXW:1];
  assign fway       = fc_q[0];
  assign flast      = &fc_q;
  assign fdirty     = valid_q[fset][fway] && dirty_q[fset][fway];
  assign flush_done = (state == FLUSH1) && !dwait;
  assign flush_skip = (state == NEXT) && !fdirty;

  assign second    = (state == WB1) || (state == FETCH1) || (state == FLUSH1);
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d  = state;
    dhit     = 1'b0;
    dmemload = '0;
    flushed  = 1'b0;
    dren     = 1'b0;
    dwen     = 1'b0;
    daddr    = '0;
    dstore   = '0;
    case (state)
      IDLE: begin
        if (halt) begin
          state_d = NEXT;
        end else if (req) begin
          if (hit) begin
            dhit = 1'b1;
            if (!dmemwen) dmemload = data_q[ridx][hway][rword];
          end else if (valid_q[ridx][lru_q[ridx]] && dirty_q[ridx][lru_q[ridx]]) begin
            state_d = WB0;
          end else begin
            state_d = FETCH0;
          end
        end
      end
      WB0, WB1: begin
        dwen   = 1'b1;
        daddr  = {tag_q[midx_q][vway_q], midx_q, second, 2'b00};
        dstore = data_q[midx_q][vway_q][second];
        if (!dwait) state_d = (state == WB0) ? WB1 : FETCH0;
      end
      FETCH0, FETCH1: begin
        dren  = 1'b1;
        daddr = {mtag_q, midx_q, second, 2'b00};
        if (!dwait) state_d = (state == FETCH0) ? FETCH1 : IDLE;
      end
      NEXT: begin
        if (fdirty)     state_d = FLUSH0;
        else if (flast) state_d = HALTED;
      end
      FLUSH0, FLUSH1: begin
        dwen   = 1'b1;
        daddr  = {tag_q[fset][fway], fset, second, 2'b00};
        dstore = data_q[fset][fway][second];
        if (!dwait) begin
          if (state == FLUSH0) state_d = FLUSH1;
          else                 state_d = flast ? HALTED : NEXT;
        end
      end
      HALTED: flushed = 1'b1;
      default: state_d = IDLE;
    endcase
  end

  // Line state, miss bookkeeping and the flush walk; a reset drops any transfer in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vway_q <= 1'b0;
      midx_q <= '0;
      mtag_q <= '0;
      fc_q   <= '0;
      for (int s = 0; s < SETS; s++) begin
        lru_q[s] <= 1'b0;
        for (int w = 0; w < 2; w++) begin
          valid_q[s][w] <= 1'b0;
          dirty_q[s][w] <= 1'b0;
        end
      end
    end else begin
      if (do_hit)   lru_q[ridx] <= ~hway;
      if (do_write) dirty_q[ridx][hway] <= 1'b1;
      if (do_miss) begin
        vway_q <= lru_q[ridx];
        midx_q <= ridx;
        mtag_q <= rtag;
      end
      if (fill1) begin
        valid_q[midx_q][vway_q] <= 1'b1;
        dirty_q[midx_q][vway_q] <= 1'b0;
      end
      if (flush_skip) fc_q <= fc_q + 1'b1;
      if (flush_done) begin
        dirty_q[fset][fway] <= 1'b0;
        fc_q                <= fc_q + 1'b1;
      end
    end
  end

  // Tags and data carry no reset; valid bits gate every use of them.
  always_ff @(posedge clk) begin
    if (do_write) data_q[ridx][hway][rword] <= dmemstore;
    if (fill0)    data_q[midx_q][vway_q][0] <= dload;
    if (fill1) begin
      data_q[midx_q][vway_q][1] <= dload;
      tag_q[midx_q][vway_q]     <= mtag_q;
    end
  end

endmodule

// File: tb/tb_dcache.sv
// Self-checking bench for dcache: directed cases plus random traffic against a
// recency-list cache model, a shadow of architectural memory and a backing memory.
module tb_dcache;
  logic        clk, rst_n, halt, dmemren, dmemwen;
  logic [31:0] dmemaddr, dmemstore, dmemload, daddr, dstore, dload;
  logic        dhit, flushed, dren, dwen, dwait;
  logic [3:0]  dbg_state;

  dcache #(.SETS(8)) dut (
    .clk(clk), .rst_n(rst_n), .halt(halt), .dmemren(dmemren), .dmemwen(dmemwen),
    .dmemaddr(dmemaddr), .dmemstore(dmemstore), .dhit(dhit), .dmemload(dmemload),
    .flushed(flushed), .dren(dren), .dwen(dwen), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard / model state ----------------
  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mem    [int unsigned];
  logic [31:0] shadow [int unsigned];
  bit          dirty_m   [int unsigned];
  bit          flush_exp [int unsigned];
  int unsigned mru_b [8];
  int unsigned lru_b [8];
  bit          mru_v [8];
  bit          lru_v [8];
  logic [31:0] exp_q [$];

  bit          flushing = 0;
  int          fixed_wait = -1;
  int          dwait_left = 0;
  bit          prev_busy = 0;
  logic [31:0] prev_addr;
  logic        prev_wen;
  logic [31:0] req_addr;
  int          n_fetch, n_wb, last_cyc;
  logic [31:0] last_load;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : init_val(a);
  endfunction

  function automatic logic [31:0] shad_rd(input logic [31:0] a);
    return shadow.exists(a) ? shadow[a] : init_val(a);
  endfunction

  // Recency model per set: mru/lru block numbers. Returns 1 on a predicted hit;
  // queues the two word addresses of a dirty victim as expected write-backs.
  function automatic bit model_access(input logic [31:0] addr, input bit w);
    int unsigned blk;
    logic [2:0]  s;
    logic [31:0] va;
    bit          h;
    blk = addr >> 3;
    s   = addr[5:3];
    h   = 1'b0;
    if (mru_v[s] && mru_b[s] == blk) begin
      h = 1'b1;
    end else if (lru_v[s] && lru_b[s] == blk) begin
      h = 1'b1;
      lru_b[s] = mru_b[s];
      mru_b[s] = blk;
    end else begin
      if (lru_v[s]) begin
        if (dirty_m.exists(lru_b[s])) begin
          va = lru_b[s] << 3;
          exp_q.push_back(va);
          exp_q.push_back(va | 32'h4);
          dirty_m.delete(lru_b[s]);
        end
      end
      if (mru_v[s]) begin
        lru_b[s] = mru_b[s];
        lru_v[s] = 1'b1;
      end
      mru_b[s] = blk;
      mru_v[s] = 1'b1;
    end
    if (w) dirty_m[blk] = 1'b1;
    return h;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic begin_req(input logic [31:0] addr);
    req_addr   = addr;
    n_fetch    = 0;
    n_wb       = 0;
    prev_busy  = 0;
    dwait_left = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 2));
  endtask

  // Called once per non-hit cycle at the falling edge: acts as the memory.
  task automatic serve_mem();
    check("rw_exclusive", 32'(dren & dwen), 32'd0);
    if (prev_busy) begin
      check("hold_addr", daddr, prev_addr);
      check("hold_wen", 32'(dwen), 32'(prev_wen));
    end
    prev_busy = 0;
    if (dren || dwen) begin
      if (dwait_left > 0) begin
        dwait = 1'b1;
        dwait_left--;
        prev_busy = 1;
        prev_addr = daddr;
        prev_wen  = dwen;
      end else begin
        dwait = 1'b0;
        if (dren) begin
          check("fetch_addr", daddr, {req_addr[31:3], n_fetch[0], 2'b00});
          dload = mem_rd(daddr);
          n_fetch++;
        end else begin
          n_wb++;
          if (flushing) begin
            check("flush_addr", 32'(flush_exp.exists(daddr) ? 1 : 0), 32'd1);
            flush_exp.delete(daddr);
          end else if (exp_q.size() > 0) begin
            check("wb_addr", daddr, exp_q.pop_front());
          end
          check("wb_data", dstore, shad_rd(daddr));
          mem[daddr] = dstore;
        end
        dwait_left = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 2));
      end
    end
  endtask

  task automatic access(input bit w, input logic [31:0] addr, input logic [31:0] wdata);
    bit exp_hit, got;
    int cyc, exp_wb;
    exp_hit = model_access(addr, w);
    exp_wb  = exp_q.size();
    begin_req(addr);
    dmemren = !w; dmemwen = w; dmemaddr = addr; dmemstore = wdata;
    cyc = 0; got = 0;
    while (!got && cyc < 300) begin
      @(negedge clk);
      if (dhit) got = 1;
      else begin
        serve_mem();
        cyc++;
      end
    end
    last_cyc  = cyc;
    last_load = dmemload;
    check("dhit_seen", 32'(got), 32'd1);
    check("hit_latency", 32'(cyc == 0), 32'(exp_hit));
    check("wb_count", n_wb, exp_wb);
    check("fetch_count", n_fetch, exp_hit ? 0 : 2);
    if (!w) check("load_data", dmemload, shad_rd(addr));
    else    shadow[addr] = wdata;
    exp_q.delete();
    @(posedge clk); #1;
    dmemren = 0; dmemwen = 0;
  endtask

  task automatic check_zero(input string p);
    check({p, "_dhit"}, 32'(dhit), 32'd0);
    check({p, "_dmemload"}, dmemload, 32'd0);
    check({p, "_flushed"}, 32'(flushed), 32'd0);
    check({p, "_dren"}, 32'(dren), 32'd0);
    check({p, "_dwen"}, 32'(dwen), 32'd0);
    check({p, "_daddr"}, daddr, 32'd0);
    check({p, "_dstore"}, dstore, 32'd0);
  endtask

  // Holds reset for two edges, then forgets cached state: dirty data still in
  // the cache is lost, so the architectural view becomes the memory image.
  task automatic do_reset();
    rst_n = 0; halt = 0; dmemren = 0; dmemwen = 0; dmemaddr = 0; dmemstore = 0;
    dwait = 1; dload = 0; fixed_wait = -1; prev_busy = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    for (int s = 0; s < 8; s++) begin mru_v[s] = 0; lru_v[s] = 0; end
    dirty_m.delete();
    exp_q.delete();
    shadow.delete();
    foreach (mem[a]) shadow[a] = mem[a];
  endtask

  task automatic do_flush();
    int cyc, exp_n;
    bit done;
    flush_exp.delete();
    foreach (dirty_m[b]) begin
      flush_exp[b << 3] = 1;
      flush_exp[(b << 3) | 4] = 1;
    end
    exp_n = flush_exp.num();
    flushing = 1;
    begin_req(32'd0);
    halt = 1;
    cyc = 0; done = 0;
    while (!done && cyc < 3000) begin
      @(negedge clk);
      if (flushed) done = 1;
      else begin
        serve_mem();
        cyc++;
      end
    end
    flushing = 0;
    check("flushed_seen", 32'(done), 32'd1);
    check("flush_writes", n_wb, exp_n);
    foreach (shadow[a]) check("mem_image", mem_rd(a), shadow[a]);
    dirty_m.delete();
    dmemren = 1; dmemaddr = 32'h40;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("sticky_flushed", 32'(flushed), 32'd1);
      check("halted_dhit", 32'(dhit), 32'd0);
      check("halted_traffic", 32'(dren | dwen), 32'd0);
    end
    @(posedge clk); #1 dmemren = 0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bit   at_wb1, h;
    int   cyc;
    logic [31:0] a;

    rst_n = 1; halt = 0; dmemren = 0; dmemwen = 0; dmemaddr = 0; dmemstore = 0;
    dwait = 1; dload = 0;
    #1 rst_n = 0;
    #1 check_zero("reset");
    do_reset();

    // cold read fetches both words, then a sibling-word hit
    mem[32'h40] = 32'hA; mem[32'h44] = 32'hB;
    shadow[32'h40] = 32'hA; shadow[32'h44] = 32'hB;
    access(0, 32'h40, 0);
    check("t1_load", last_load, 32'hA);
    access(0, 32'h44, 0);
    check("t1_hit_load", last_load, 32'hB);
    check("t1_hit_cycles", last_cyc, 0);

    // write hit then read back
    access(1, 32'h40, 32'hDEAD);
    check("t2_write_cycles", last_cyc, 0);
    access(0, 32'h40, 0);
    check("t2_readback", last_load, 32'hDEAD);

    // conflict eviction of the dirty 0x40 block
    access(0, 32'h240, 0);
    access(0, 32'h240, 0);
    access(0, 32'h440, 0);
    check("t3_wb_words", n_wb, 2);

    // slow memory: three busy cycles per word
    fixed_wait = 3;
    access(0, 32'h18, 0);
    check("t4_latency", last_cyc, 9);
    fixed_wait = -1;

    // random traffic over 4 sets x 4 tags
    for (int i = 0; i < 250; i++) begin
      a = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 3) << 3) | ($urandom_range(0, 1) << 2);
      access(1'($urandom_range(0, 1)), a, $urandom);
    end
    do_flush();

    // flush with exactly three dirty lines
    rst_n = 0;
    #1 check_zero("t5_rst");
    do_reset();
    access(1, 32'h40, 32'h5A5A_0001);
    access(1, 32'h240, 32'h5A5A_0002);
    access(1, 32'h88, 32'h5A5A_0003);
    do_flush();
    check("t5_six_writes", n_wb, 6);

    // reset in the middle of the second write-back word
    rst_n = 0;
    #1;
    do_reset();
    access(1, 32'h40, 32'h1111_0000);
    access(1, 32'h240, 32'h2222_0000);
    h = model_access(32'h440, 0);
    check("t6_predict_miss", 32'(h), 32'd0);
    fixed_wait = 3;
    begin_req(32'h440);
    dmemren = 1; dmemaddr = 32'h440;
    cyc = 0; at_wb1 = 0;
    while (!at_wb1 && cyc < 100) begin
      @(negedge clk);
      if (dwen && daddr == 32'h44) at_wb1 = 1;
      else begin
        serve_mem();
        cyc++;
      end
    end
    check("t6_reach_wb1", 32'(at_wb1), 32'd1);
    rst_n = 0;
    #1 check_zero("t6");
    do_reset();
    access(0, 32'h240, 0);
    access(0, 32'h40, 0);
    check("t6_wb0_kept", last_load, 32'h1111_0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
